// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes the asynchronous PLL `locked` flag into
// clk10, qualifies lock stability, then releases a synchronous reset and
// `ready` to downstream clk10 logic. Counts lock-loss events seen in RUN and
// drives a heartbeat LED (fast blink while acquiring, slow blink in RUN).
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned STABLE_CYCLES   = 1000,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned LED_FAST_BIT    = 19,
  parameter int unsigned LED_SLOW_BIT    = 22
) (
  input  logic             clk10,
  input  logic             rst,
  input  logic             locked,
  input  logic             cnt_clr,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic             led
);

  // Counter widths; a one-cycle window still needs a 1-bit counter.
  localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned QUAL_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HB_W   = LED_SLOW_BIT + 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    QUAL      = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [QUAL_W-1:0]      qual_cnt;
  logic [HB_W-1:0]        heartbeat;

  // Last flop of the synchronizer chain is the only view of `locked`.
  assign locked_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous lock flag.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // Free-running heartbeat; wraps naturally, cleared only by rst.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      heartbeat <= '0;
    end else begin
      heartbeat <= heartbeat + HB_W'(1);
    end
  end

  // LED follows the slow heartbeat bit in RUN, the fast bit otherwise.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      led <= 1'b0;
    end else if (state == RUN) begin
      led <= heartbeat[LED_SLOW_BIT];
    end else begin
      led <= heartbeat[LED_FAST_BIT];
    end
  end

  // Supervisor FSM with registered rst_out/ready and the lock-loss counter.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      qual_cnt      <= '0;
      rst_out       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      // A lone clear wins unless a loss lands on the same edge (handled in RUN).
      if (cnt_clr) begin
        lock_loss_cnt <= '0;
      end

      case (state)
        HOLD: begin
          rst_out <= 1'b1;
          ready   <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state <= WAIT_LOCK;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        WAIT_LOCK: begin
          rst_out <= 1'b1;
          ready   <= 1'b0;
          if (locked_s) begin
            state    <= QUAL;
            qual_cnt <= '0;
          end
        end

        QUAL: begin
          if (!locked_s) begin
            // Lock dropped before qualifying: retry, not a counted loss.
            state   <= WAIT_LOCK;
            rst_out <= 1'b1;
            ready   <= 1'b0;
          end else if (qual_cnt == QUAL_LAST) begin
            state   <= RUN;
            rst_out <= 1'b0;
            ready   <= 1'b1;
          end else begin
            qual_cnt <= qual_cnt + QUAL_W'(1);
            rst_out  <= 1'b1;
            ready    <= 1'b0;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state   <= LOST;
            rst_out <= 1'b1;
            ready   <= 1'b0;
            // Coincident clear keeps this event as the first count.
            if (cnt_clr) begin
              lock_loss_cnt <= CNT_W'(1);
            end else if (lock_loss_cnt != CNT_MAX) begin
              lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
          end else begin
            rst_out <= 1'b0;
            ready   <= 1'b1;
          end
        end

        LOST: begin
          state    <= HOLD;
          hold_cnt <= '0;
          rst_out  <= 1'b1;
          ready    <= 1'b0;
        end

        default: begin
          state    <= HOLD;
          hold_cnt <= '0;
          rst_out  <= 1'b1;
          ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
